// File: rtl/ahb_bus_matrix_input_stage_if.sv
// Bus bundle between one AHB master port and its bus-matrix input stage.
// The slave modport is the input stage; the master modport is the surrounding fabric and master.
interface ahb_bus_matrix_input_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PROT_W = 4
);
  // Master-side address phase
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [PROT_W-1:0] HPROTS;
  logic              HMASTLOCKS;
  logic              HREADYS;
  // Responses back to the master
  logic              HREADYOUTS;
  logic              HRESPS;
  // Toward decoder / arbiters
  logic              sel_out;
  logic [ADDR_W-1:0] addr_out;
  logic [1:0]        trans_out;
  logic              write_out;
  logic [2:0]        size_out;
  logic [2:0]        burst_out;
  logic [PROT_W-1:0] prot_out;
  logic              mastlock_out;
  logic              req_out;
  logic              held_tran;
  // From arbiter and granted slave path
  logic              grant_in;
  logic              hready_m;
  logic              hresp_m;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
    input  grant_in, hready_m, hresp_m,
    output HREADYOUTS, HRESPS,
    output sel_out, addr_out, trans_out, write_out, size_out, burst_out, prot_out,
    output mastlock_out, req_out, held_tran
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
    output grant_in, hready_m, hresp_m,
    input  HREADYOUTS, HRESPS,
    input  sel_out, addr_out, trans_out, write_out, size_out, burst_out, prot_out,
    input  mastlock_out, req_out, held_tran
  );
endinterface

// File: rtl/ahb_bus_matrix_input_stage.sv
// Slave-side input stage for one bus-matrix master port: forwards the live address phase,
// holds it when the arbiter does not accept it, and stalls the master until it is granted.
// Optional feature macro AHB_INSTAGE_ERR_CANCEL_EN: a held transfer is dropped on the first
// ERROR cycle of the preceding data phase instead of being requested afterwards.
module ahb_bus_matrix_input_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PROT_W = 4
) (
  input logic                         HCLK,
  input logic                         HRESET,
  ahb_bus_matrix_input_stage_if.slave bus
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;
  localparam logic [2:0] BurstIncr   = 3'b001;

  // Encoded as {data_q, pend_q}
  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StPend     = 2'b01,
    StData     = 2'b10,
    StDataPend = 2'b11
  } state_e;

  state_e state_q, state_d;
  logic   data_q, pend_q;
  logic   data_d, pend_d;
  logic   new_tran;
  logic   hold_en;

  logic              hold_sel_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [1:0]        hold_trans_q;
  logic              hold_write_q;
  logic [2:0]        hold_size_q;
  logic [2:0]        hold_burst_q;
  logic [PROT_W-1:0] hold_prot_q;
  logic              hold_lock_q;

  assign data_q   = state_q[1];
  assign pend_q   = state_q[0];
  assign new_tran = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
  // While a transfer is held the master is stalled; any address seen then is ignored.
  assign hold_en  = bus.HREADYS & ~pend_q;

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: pend and data flags evolve independently and may both change in one cycle
  always_comb begin
    pend_d = pend_q;
    data_d = data_q;
    if (bus.grant_in) begin
      pend_d = 1'b0;
    end else if (new_tran) begin
      pend_d = 1'b1;
    end
`ifdef AHB_INSTAGE_ERR_CANCEL_EN
    if (data_q && bus.hresp_m && !bus.hready_m && pend_q) begin
      pend_d = 1'b0;
    end
`endif
    if (bus.grant_in) begin
      data_d = 1'b1;
    end else if (bus.hready_m) begin
      data_d = 1'b0;
    end
    state_d = state_e'({data_d, pend_d});
  end

  // Address-phase hold register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hold_sel_q   <= 1'b0;
      hold_addr_q  <= '0;
      hold_trans_q <= TransIdle;
      hold_write_q <= 1'b0;
      hold_size_q  <= '0;
      hold_burst_q <= '0;
      hold_prot_q  <= '0;
      hold_lock_q  <= 1'b0;
    end else if (hold_en) begin
      hold_sel_q   <= bus.HSELS;
      hold_addr_q  <= bus.HADDRS;
      hold_trans_q <= bus.HTRANSS;
      hold_write_q <= bus.HWRITES;
      hold_size_q  <= bus.HSIZES;
      hold_burst_q <= bus.HBURSTS;
      hold_prot_q  <= bus.HPROTS;
      hold_lock_q  <= bus.HMASTLOCKS;
    end
  end

  // Output mux: held transfer when pending, live master signals otherwise
  always_comb begin
    bus.sel_out      = bus.HSELS;
    bus.addr_out     = bus.HADDRS;
    bus.trans_out    = bus.HTRANSS;
    bus.write_out    = bus.HWRITES;
    bus.size_out     = bus.HSIZES;
    bus.burst_out    = bus.HBURSTS;
    bus.prot_out     = bus.HPROTS;
    bus.mastlock_out = bus.HMASTLOCKS;
    bus.held_tran    = 1'b0;
    if (pend_q) begin
      bus.sel_out      = hold_sel_q;
      bus.addr_out     = hold_addr_q;
      bus.trans_out    = hold_trans_q;
      bus.write_out    = hold_write_q;
      bus.size_out     = hold_size_q;
      bus.burst_out    = hold_burst_q;
      bus.prot_out     = hold_prot_q;
      bus.mastlock_out = hold_lock_q;
      bus.held_tran    = 1'b1;
      // Arbitration broke the burst, so a held SEQ beat restarts as an undefined INCR
      if (hold_trans_q == TransSeq) begin
        bus.trans_out = TransNonseq;
        bus.burst_out = BurstIncr;
      end
    end
  end

  assign bus.req_out    = pend_q | (bus.HSELS & bus.HTRANSS[1]);
  assign bus.HREADYOUTS = data_q ? bus.hready_m : ~pend_q;
  assign bus.HRESPS     = data_q & bus.hresp_m;

`ifndef SYNTHESIS
  // A new master address while a transfer is held would be lost.
  assert property (@(posedge HCLK) disable iff (HRESET) !(pend_q && bus.HREADYS));
`endif

endmodule

// File: tb/tb_ahb_bus_matrix_input_stage.sv
// Self-checking bench for ahb_bus_matrix_input_stage: directed scenarios plus a randomized run
// against a transaction-level model (a 0/1-entry queue of captured transfers and a data-phase flag).
module tb_ahb_bus_matrix_input_stage;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned PROT_W = 4;
  localparam int unsigned VW     = ADDR_W + PROT_W + 15;
`ifdef AHB_INSTAGE_ERR_CANCEL_EN
  localparam bit Cancel = 1'b1;
`else
  localparam bit Cancel = 1'b0;
`endif

  logic HCLK = 1'b0;
  logic HRESET;

  ahb_bus_matrix_input_stage_if #(.ADDR_W(ADDR_W), .PROT_W(PROT_W)) bus ();

  ahb_bus_matrix_input_stage #(.ADDR_W(ADDR_W), .PROT_W(PROT_W)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [PROT_W-1:0] prot;
    logic              lock;
  } xfer_t;

  // Reference model state
  xfer_t held[$];
  bit    m_data;
  // Model expectations
  logic [VW-1:0] exp_vec;
  logic          exp_req;

  function automatic xfer_t live_xfer();
    xfer_t x;
    x.sel   = bus.HSELS;
    x.addr  = bus.HADDRS;
    x.trans = bus.HTRANSS;
    x.write = bus.HWRITES;
    x.size  = bus.HSIZES;
    x.burst = bus.HBURSTS;
    x.prot  = bus.HPROTS;
    x.lock  = bus.HMASTLOCKS;
    return x;
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.HREADYOUTS, bus.HRESPS, bus.sel_out, bus.addr_out, bus.trans_out, bus.write_out,
            bus.size_out, bus.burst_out, bus.prot_out, bus.mastlock_out, bus.req_out,
            bus.held_tran};
  endfunction

  task automatic model_outputs();
    xfer_t x;
    logic  h, rdy, rsp;
    if (held.size() != 0) begin
      x = held[0];
      h = 1'b1;
      if (x.trans == 2'b11) begin
        x.trans = 2'b10;
        x.burst = 3'b001;
      end
    end else begin
      x = live_xfer();
      h = 1'b0;
    end
    exp_req = (held.size() != 0) || (bus.HSELS && bus.HTRANSS[1]);
    rdy     = m_data ? bus.hready_m : (held.size() == 0);
    rsp     = m_data ? bus.hresp_m : 1'b0;
    exp_vec = {rdy, rsp, x.sel, x.addr, x.trans, x.write, x.size, x.burst, x.prot, x.lock,
               exp_req, h};
  endtask

  task automatic model_clock();
    bit    new_t, cancel, next_data;
    xfer_t x;
    new_t  = bus.HSELS && bus.HTRANSS[1] && bus.HREADYS;
    cancel = Cancel && m_data && bus.hresp_m && !bus.hready_m;
    next_data = bus.grant_in ? 1'b1 : (bus.hready_m ? 1'b0 : m_data);
    if (bus.grant_in || cancel) begin
      held.delete();
    end else if (new_t && held.size() == 0) begin
      x = live_xfer();
      held.push_back(x);
    end
    m_data = next_data;
  endtask

  task automatic set_idle();
    bus.HSELS      = 1'b0;
    bus.HADDRS     = '0;
    bus.HTRANSS    = 2'b00;
    bus.HWRITES    = 1'b0;
    bus.HSIZES     = 3'b000;
    bus.HBURSTS    = 3'b000;
    bus.HPROTS     = '0;
    bus.HMASTLOCKS = 1'b0;
    bus.HREADYS    = 1'b0;
    bus.grant_in   = 1'b0;
    bus.hready_m   = 1'b1;
    bus.hresp_m    = 1'b0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a, input logic [1:0] t, input logic [2:0] b);
    bus.HSELS   = 1'b1;
    bus.HADDRS  = a;
    bus.HTRANSS = t;
    bus.HBURSTS = b;
    bus.HWRITES = 1'b1;
    bus.HSIZES  = 3'b010;
    bus.HPROTS  = 4'h3;
    bus.HREADYS = 1'b1;
  endtask

  task automatic tick();
    @(posedge HCLK);
    model_clock();
    #1;
  endtask

  task automatic sample();
    @(negedge HCLK);
    model_outputs();
  endtask

  task automatic do_reset();
    set_idle();
    HRESET = 1'b1;
    held.delete();
    m_data = 1'b0;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    sample();
    checks++;
    if (bus.HREADYOUTS !== 1'b1 || bus.req_out !== 1'b0 || bus.held_tran !== 1'b0 ||
        bus.HRESPS !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%b req=%b held=%b resp=%b want 1 0 0 0",
               bus.HREADYOUTS, bus.req_out, bus.held_tran, bus.HRESPS);
    end
    issue(32'h2000_0010, 2'b10, 3'b000);
    tick();
    set_idle();
    sample();
    checks++;
    if (bus.held_tran !== 1'b1 || bus.addr_out !== 32'h2000_0010) begin
      errors++;
      $display("FAIL reset_prep_held: got held=%b addr=%h want 1 20000010",
               bus.held_tran, bus.addr_out);
    end
    #2 HRESET = 1'b1;
    #1;
    checks++;
    if (bus.HREADYOUTS !== 1'b1 || bus.req_out !== 1'b0 || bus.held_tran !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got rdy=%b req=%b held=%b want 1 0 0",
               bus.HREADYOUTS, bus.req_out, bus.held_tran);
    end
    held.delete();
    m_data = 1'b0;
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++;
      if (bus.req_out !== 1'b0 || bus.held_tran !== 1'b0 || bus.addr_out === 32'h2000_0010)
      begin
        errors++;
        $display("FAIL reset_after[%0d]: got req=%b held=%b addr=%h want 0 0 not-20000010",
                 i, bus.req_out, bus.held_tran, bus.addr_out);
      end
      tick();
    end
  endtask

  task automatic test_granted_same_cycle();
    do_reset();
    issue(32'h1000_0000, 2'b10, 3'b000);
    bus.grant_in = 1'b1;
    sample();
    checks++;
    if (bus.HREADYOUTS !== 1'b1 || bus.held_tran !== 1'b0 || bus.req_out !== 1'b1 ||
        bus.addr_out !== 32'h1000_0000 || dut_vec() !== exp_vec) begin
      errors++;
      $display("FAIL grant_now_addr: got %h want %h", dut_vec(), exp_vec);
    end
    tick();
    set_idle();
    bus.hresp_m = 1'b1;
    sample();
    checks++;
    if (bus.HREADYOUTS !== 1'b1 || bus.HRESPS !== 1'b1 || bus.held_tran !== 1'b0) begin
      errors++;
      $display("FAIL grant_now_data: got rdy=%b resp=%b held=%b want 1 1 0",
               bus.HREADYOUTS, bus.HRESPS, bus.held_tran);
    end
    tick();
    set_idle();
    bus.hready_m = 1'b0;
    bus.hresp_m  = 1'b1;
    sample();
    checks++;
    if (bus.HREADYOUTS !== 1'b1 || bus.HRESPS !== 1'b0) begin
      errors++;
      $display("FAIL grant_now_after: got rdy=%b resp=%b want 1 0", bus.HREADYOUTS, bus.HRESPS);
    end
    tick();
  endtask

  task automatic test_held_wait();
    int low    = 0;
    int held_n = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_idle();
      if (i == 0) issue(32'h1000_0004, 2'b10, 3'b000);
      bus.grant_in = (i == 3);
      bus.hready_m = (i != 4);
      sample();
      if (bus.HREADYOUTS === 1'b0) low++;
      if (bus.held_tran === 1'b1) held_n++;
      if (i <= 3) begin
        checks++;
        if (bus.req_out !== 1'b1 || bus.addr_out !== 32'h1000_0004) begin
          errors++;
          $display("FAIL held_wait[%0d]: got req=%b addr=%h want 1 10000004",
                   i, bus.req_out, bus.addr_out);
        end
      end
      tick();
    end
    checks++;
    if (low != 4) begin
      errors++;
      $display("FAIL held_wait_stall: got %0d low cycles want 4", low);
    end
    checks++;
    if (held_n != 3) begin
      errors++;
      $display("FAIL held_wait_heldcnt: got %0d held cycles want 3", held_n);
    end
  endtask

  task automatic test_seq_conversion();
    do_reset();
    issue(32'h1000_0008, 2'b11, 3'b011);
    sample();
    checks++;
    if (bus.trans_out !== 2'b11 || bus.burst_out !== 3'b011) begin
      errors++;
      $display("FAIL seq_live: got trans=%b burst=%b want 11 011", bus.trans_out, bus.burst_out);
    end
    tick();
    set_idle();
    sample();
    checks++;
    if (bus.trans_out !== 2'b10 || bus.burst_out !== 3'b001 || bus.held_tran !== 1'b1 ||
        bus.addr_out !== 32'h1000_0008) begin
      errors++;
      $display("FAIL seq_held: got trans=%b burst=%b held=%b addr=%h want 10 001 1 10000008",
               bus.trans_out, bus.burst_out, bus.held_tran, bus.addr_out);
    end
    bus.grant_in = 1'b1;
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_data_pend();
    do_reset();
    issue(32'h3000_0000, 2'b10, 3'b000);
    bus.grant_in = 1'b1;
    tick();
    set_idle();
    issue(32'h3000_0004, 2'b10, 3'b000);
    bus.hready_m = 1'b0;
    tick();
    set_idle();
    bus.hready_m = 1'b0;
    sample();
    checks++;
    if (bus.HREADYOUTS !== 1'b0 || bus.held_tran !== 1'b1 || bus.addr_out !== 32'h3000_0004) begin
      errors++;
      $display("FAIL dp_wait: got rdy=%b held=%b addr=%h want 0 1 30000004",
               bus.HREADYOUTS, bus.held_tran, bus.addr_out);
    end
    tick();
    set_idle();
    bus.grant_in = 1'b1;
    sample();
    checks++;
    if (bus.HREADYOUTS !== 1'b1 || bus.req_out !== 1'b1) begin
      errors++;
      $display("FAIL dp_grant: got rdy=%b req=%b want 1 1", bus.HREADYOUTS, bus.req_out);
    end
    tick();
    set_idle();
    bus.hready_m = 1'b0;
    sample();
    checks++;
    if (bus.HREADYOUTS !== 1'b0 || bus.held_tran !== 1'b0 || bus.req_out !== 1'b0) begin
      errors++;
      $display("FAIL dp_to_data: got rdy=%b held=%b req=%b want 0 0 0",
               bus.HREADYOUTS, bus.held_tran, bus.req_out);
    end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_error();
    int resp_n = 0;
    do_reset();
    issue(32'h4000_0000, 2'b10, 3'b000);
    bus.grant_in = 1'b1;
    tick();
    set_idle();
    issue(32'h4000_0004, 2'b10, 3'b000);
    bus.hready_m = 1'b0;
    tick();
    set_idle();
    bus.hready_m = 1'b0;
    bus.hresp_m  = 1'b1;
    sample();
    if (bus.HRESPS === 1'b1) resp_n++;
    checks++;
    if (bus.HREADYOUTS !== 1'b0 || bus.held_tran !== 1'b1) begin
      errors++;
      $display("FAIL err_first: got rdy=%b held=%b want 0 1", bus.HREADYOUTS, bus.held_tran);
    end
    tick();
    set_idle();
    bus.hresp_m = 1'b1;
    sample();
    if (bus.HRESPS === 1'b1) resp_n++;
    checks++;
    if (bus.HREADYOUTS !== 1'b1 || bus.req_out !== !Cancel || bus.held_tran !== !Cancel) begin
      errors++;
      $display("FAIL err_second: got rdy=%b req=%b held=%b want 1 %b %b",
               bus.HREADYOUTS, bus.req_out, bus.held_tran, !Cancel, !Cancel);
    end
    checks++;
    if (resp_n != 2) begin
      errors++;
      $display("FAIL err_resp_cycles: got %0d want 2", resp_n);
    end
    tick();
    set_idle();
    sample();
    checks++;
    if (bus.req_out !== !Cancel || bus.HREADYOUTS !== Cancel || bus.HRESPS !== 1'b0) begin
      errors++;
      $display("FAIL err_after: got req=%b rdy=%b resp=%b want %b %b 0",
               bus.req_out, bus.HREADYOUTS, bus.HRESPS, !Cancel, Cancel);
    end
    if (!Cancel) begin
      checks++;
      if (bus.addr_out !== 32'h4000_0004) begin
        errors++;
        $display("FAIL err_regrant_addr: got %h want 40000004", bus.addr_out);
      end
      bus.grant_in = 1'b1;
    end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.HSELS      = ($urandom_range(3) != 0);
      bus.HTRANSS    = 2'($urandom_range(3));
      bus.HADDRS     = ADDR_W'($urandom());
      bus.HWRITES    = 1'($urandom_range(1));
      bus.HSIZES     = 3'($urandom_range(7));
      bus.HBURSTS    = 3'($urandom_range(7));
      bus.HPROTS     = PROT_W'($urandom());
      bus.HMASTLOCKS = 1'($urandom_range(1));
      bus.HREADYS    = (held.size() == 0) && ($urandom_range(3) != 0);
      bus.hready_m   = ($urandom_range(3) != 0);
      bus.hresp_m    = ($urandom_range(4) == 0);
      model_outputs();
      // The arbiter only accepts a requested transfer while the slave path is ready
      bus.grant_in   = exp_req && !(m_data && !bus.hready_m) && ($urandom_range(1) == 1);
      sample();
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), exp_vec);
      end
      tick();
    end
  endtask

  initial begin
    HRESET = 1'b1;
    set_idle();
    test_reset();
    test_granted_same_cycle();
    test_held_wait();
    test_seq_conversion();
    test_data_pend();
    test_error();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
